// File: rtl/buf_pool_ctrl_pkg.sv
// Shared owner codes and sizing helper for the buffer-pool ownership scheduler.
package buf_pool_ctrl_pkg;

  localparam logic [1:0] OWN_FREE = 2'b00;
  localparam logic [1:0] OWN_SN   = 2'b01;
  localparam logic [1:0] OWN_CPU  = 2'b10;
  localparam logic [1:0] OWN_FWD  = 2'b11;

  // Bits needed to index n entries (at least one).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buf_pool_ctrl_if.sv
// Event pulses from the three agents and the ownership/status outputs of buf_pool_ctrl.
interface buf_pool_ctrl_if #(
  parameter int NUM_BUFS  = 4,
  parameter int IDX_WIDTH = 2
);
  logic                   sn_done;
  logic                   cpu_acc;
  logic                   cpu_rej;
  logic                   fwd_done;
  logic [IDX_WIDTH-1:0]   sn_sel;
  logic                   sn_valid;
  logic [IDX_WIDTH-1:0]   cpu_sel;
  logic                   cpu_valid;
  logic [IDX_WIDTH-1:0]   fwd_sel;
  logic                   fwd_valid;
  logic [2*NUM_BUFS-1:0]  buf_owner;
  logic [NUM_BUFS-1:0]    len_rst;
  logic [IDX_WIDTH:0]     free_count;
  logic                   proto_err;

  modport master (
    output sn_done, cpu_acc, cpu_rej, fwd_done,
    input  sn_sel, sn_valid, cpu_sel, cpu_valid, fwd_sel, fwd_valid,
           buf_owner, len_rst, free_count, proto_err
  );

  modport slave (
    input  sn_done, cpu_acc, cpu_rej, fwd_done,
    output sn_sel, sn_valid, cpu_sel, cpu_valid, fwd_sel, fwd_valid,
           buf_owner, len_rst, free_count, proto_err
  );
endinterface

// File: rtl/idx_fifo.sv
// Circular FIFO of buffer indices; optional second write port lands behind the first.
module idx_fifo
  import buf_pool_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CW       = 3,
  parameter bit          DUAL_WR  = 1'b0,
  parameter bit          INIT_SEQ = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic [WIDTH-1:0] data0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data1,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int unsigned PW = idx_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, wr1_ptr, wr_ptr_d;
  logic             p1, pop_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    p1       = DUAL_WR && push1;
    pop_ok   = pop && (count != '0);
    wr1_ptr  = push0 ? inc(wr_ptr) : wr_ptr;
    wr_ptr_d = p1 ? inc(wr1_ptr) : wr1_ptr;
  end

  assign head = mem[rd_ptr];

  // INIT_SEQ preloads indices 1..DEPTH-1 so the pool starts with buffer 0 handed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= (INIT_SEQ && (i < DEPTH - 1)) ? WIDTH'(i + 1) : '0;
      rd_ptr <= '0;
      wr_ptr <= INIT_SEQ ? PW'(DEPTH - 1) : '0;
      count  <= INIT_SEQ ? CW'(DEPTH - 1) : '0;
    end else begin
      if (push0) mem[wr_ptr]  <= data0;
      if (p1)    mem[wr1_ptr] <= data1;
      if (pop_ok) rd_ptr <= inc(rd_ptr);
      wr_ptr <= wr_ptr_d;
      count  <= count + CW'(push0) + CW'(p1) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/buf_pool_ctrl.sv
// Ownership scheduler rotating NUM_BUFS packet buffers between snooper, CPU and forwarder.
module buf_pool_ctrl
  import buf_pool_ctrl_pkg::*;
#(
  parameter int NUM_BUFS  = 4,
  parameter int IDX_WIDTH = 2
) (
  input logic            clk,
  input logic            rst,
  buf_pool_ctrl_if.slave bus
);
  localparam int unsigned CW = IDX_WIDTH + 1;

  logic [IDX_WIDTH-1:0]  sn_sel_q, cpu_sel_q, fwd_sel_q;
  logic [IDX_WIDTH-1:0]  sn_sel_d, cpu_sel_d, fwd_sel_d;
  logic                  sn_valid_q, cpu_valid_q, fwd_valid_q;
  logic                  sn_valid_d, cpu_valid_d, fwd_valid_d;
  logic [2*NUM_BUFS-1:0] owner_q, owner_d;
  logic [NUM_BUFS-1:0]   len_rst_q, len_rst_d;
  logic                  err_q, err_d;

  logic sn_ev, acc_ev, rej_ev, fwd_ev;
  logic sn_need, cpu_need, fwd_need;
  logic free_byp, cq_byp, wq_byp;

  logic                 fq_push0, fq_push1, fq_pop;
  logic [IDX_WIDTH-1:0] fq_data0, fq_head;
  logic [CW-1:0]        fq_cnt;
  logic                 cq_push, cq_pop;
  logic [IDX_WIDTH-1:0] cq_head;
  logic [CW-1:0]        cq_cnt;
  logic                 wq_push, wq_pop;
  logic [IDX_WIDTH-1:0] wq_head;
  logic [CW-1:0]        wq_cnt;

  always_comb begin
    sn_ev  = bus.sn_done  & sn_valid_q;
    acc_ev = bus.cpu_acc  & cpu_valid_q;
    rej_ev = bus.cpu_rej  & cpu_valid_q & ~bus.cpu_acc;
    fwd_ev = bus.fwd_done & fwd_valid_q;
    err_d  = (bus.sn_done & ~sn_valid_q)
           | ((bus.cpu_acc | bus.cpu_rej) & ~cpu_valid_q)
           | (bus.cpu_acc & bus.cpu_rej & cpu_valid_q)
           | (bus.fwd_done & ~fwd_valid_q);

    sn_need  = ~sn_valid_q  | sn_ev;
    cpu_need = ~cpu_valid_q | acc_ev | rej_ev;
    fwd_need = ~fwd_valid_q | fwd_ev;

    // Free queue: a rejected buffer ranks ahead of a forwarded one; on bypass the
    // front-ranked buffer goes to the snooper and any second one is still queued.
    free_byp = sn_need & (fq_cnt == '0) & (rej_ev | fwd_ev);
    fq_pop   = sn_need & (fq_cnt != '0);
    if (free_byp) begin
      fq_push0 = rej_ev & fwd_ev;
      fq_data0 = fwd_sel_q;
    end else begin
      fq_push0 = rej_ev | fwd_ev;
      fq_data0 = rej_ev ? cpu_sel_q : fwd_sel_q;
    end
    fq_push1 = ~free_byp & rej_ev & fwd_ev;

    cq_byp  = cpu_need & (cq_cnt == '0) & sn_ev;
    cq_push = sn_ev & ~cq_byp;
    cq_pop  = cpu_need & (cq_cnt != '0);

    wq_byp  = fwd_need & (wq_cnt == '0) & acc_ev;
    wq_push = acc_ev & ~wq_byp;
    wq_pop  = fwd_need & (wq_cnt != '0);

    sn_valid_d = sn_valid_q;
    sn_sel_d   = sn_sel_q;
    if (sn_need) begin
      sn_valid_d = fq_pop | free_byp;
      if (fq_pop)        sn_sel_d = fq_head;
      else if (free_byp) sn_sel_d = rej_ev ? cpu_sel_q : fwd_sel_q;
    end

    cpu_valid_d = cpu_valid_q;
    cpu_sel_d   = cpu_sel_q;
    if (cpu_need) begin
      cpu_valid_d = cq_pop | cq_byp;
      if (cq_pop)      cpu_sel_d = cq_head;
      else if (cq_byp) cpu_sel_d = sn_sel_q;
    end

    fwd_valid_d = fwd_valid_q;
    fwd_sel_d   = fwd_sel_q;
    if (fwd_need) begin
      fwd_valid_d = wq_pop | wq_byp;
      if (wq_pop)      fwd_sel_d = wq_head;
      else if (wq_byp) fwd_sel_d = cpu_sel_q;
    end

    owner_d   = '0;
    len_rst_d = '0;
    for (int unsigned i = 0; i < NUM_BUFS; i++) begin
      if (sn_valid_d && sn_sel_d == IDX_WIDTH'(i))   owner_d[2*i +: 2] = OWN_SN;
      if (cpu_valid_d && cpu_sel_d == IDX_WIDTH'(i)) owner_d[2*i +: 2] = OWN_CPU;
      if (fwd_valid_d && fwd_sel_d == IDX_WIDTH'(i)) owner_d[2*i +: 2] = OWN_FWD;
      len_rst_d[i] = (rej_ev && cpu_sel_q == IDX_WIDTH'(i))
                  || (fwd_ev && fwd_sel_q == IDX_WIDTH'(i));
    end
  end

  idx_fifo #(.DEPTH(NUM_BUFS), .WIDTH(IDX_WIDTH), .CW(CW), .DUAL_WR(1'b1), .INIT_SEQ(1'b1)) u_free_q (
    .clk(clk), .rst(rst),
    .push0(fq_push0), .data0(fq_data0), .push1(fq_push1), .data1(fwd_sel_q),
    .pop(fq_pop), .head(fq_head), .count(fq_cnt)
  );

  idx_fifo #(.DEPTH(NUM_BUFS), .WIDTH(IDX_WIDTH), .CW(CW), .DUAL_WR(1'b0), .INIT_SEQ(1'b0)) u_cpu_q (
    .clk(clk), .rst(rst),
    .push0(cq_push), .data0(sn_sel_q), .push1(1'b0), .data1('0),
    .pop(cq_pop), .head(cq_head), .count(cq_cnt)
  );

  idx_fifo #(.DEPTH(NUM_BUFS), .WIDTH(IDX_WIDTH), .CW(CW), .DUAL_WR(1'b0), .INIT_SEQ(1'b0)) u_fwd_q (
    .clk(clk), .rst(rst),
    .push0(wq_push), .data0(cpu_sel_q), .push1(1'b0), .data1('0),
    .pop(wq_pop), .head(wq_head), .count(wq_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sn_sel_q    <= '0;
      sn_valid_q  <= 1'b1;
      cpu_sel_q   <= '0;
      cpu_valid_q <= 1'b0;
      fwd_sel_q   <= '0;
      fwd_valid_q <= 1'b0;
      owner_q     <= {{(2*NUM_BUFS-2){1'b0}}, OWN_SN};
      len_rst_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      sn_sel_q    <= sn_sel_d;
      sn_valid_q  <= sn_valid_d;
      cpu_sel_q   <= cpu_sel_d;
      cpu_valid_q <= cpu_valid_d;
      fwd_sel_q   <= fwd_sel_d;
      fwd_valid_q <= fwd_valid_d;
      owner_q     <= owner_d;
      len_rst_q   <= len_rst_d;
      err_q       <= err_d;
    end
  end

  assign bus.sn_sel     = sn_sel_q;
  assign bus.sn_valid   = sn_valid_q;
  assign bus.cpu_sel    = cpu_sel_q;
  assign bus.cpu_valid  = cpu_valid_q;
  assign bus.fwd_sel    = fwd_sel_q;
  assign bus.fwd_valid  = fwd_valid_q;
  assign bus.buf_owner  = owner_q;
  assign bus.len_rst    = len_rst_q;
  assign bus.free_count = fq_cnt;
  assign bus.proto_err  = err_q;

endmodule

// File: tb/tb_buf_pool_ctrl.sv
// Randomized bench for buf_pool_ctrl against a queue-based ownership model, plus directed literal checks.
module tb_buf_pool_ctrl;
  localparam int NB = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buf_pool_ctrl_if #(.NUM_BUFS(NB), .IDX_WIDTH(IW)) bus ();
  buf_pool_ctrl #(.NUM_BUFS(NB), .IDX_WIDTH(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Model: ag[k] is the buffer held by agent k (-1 none); q[k] is agent k's source queue.
  // k = 0 snooper/free queue, 1 CPU/CPU-pending, 2 forwarder/forward-pending.
  int          ag [3];
  int          q  [3][$];
  logic [NB-1:0] m_len;
  logic        m_err;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ag[0] = 0; ag[1] = -1; ag[2] = -1;
    for (int k = 0; k < 3; k++) q[k].delete();
    for (int b = 1; b < NB; b++) q[0].push_back(b);
    m_len = '0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit r, input bit f);
    int  arr [3][$];
    bit  se, ae, re, fe;
    se = s && ag[0] >= 0;
    ae = a && ag[1] >= 0;
    re = r && !a && ag[1] >= 0;
    fe = f && ag[2] >= 0;
    m_err = (s && ag[0] < 0) || ((a || r) && ag[1] < 0) || (a && r && ag[1] >= 0) || (f && ag[2] < 0);
    m_len = '0;
    if (re) m_len[ag[1]] = 1'b1;
    if (fe) m_len[ag[2]] = 1'b1;
    if (re) arr[0].push_back(ag[1]);
    if (fe) arr[0].push_back(ag[2]);
    if (se) arr[1].push_back(ag[0]);
    if (ae) arr[2].push_back(ag[1]);
    if (se) ag[0] = -1;
    if (ae || re) ag[1] = -1;
    if (fe) ag[2] = -1;
    for (int k = 0; k < 3; k++) begin
      if (ag[k] < 0) begin
        if (q[k].size() > 0)        ag[k] = q[k].pop_front();
        else if (arr[k].size() > 0) ag[k] = arr[k].pop_front();
      end
      while (arr[k].size() > 0) q[k].push_back(arr[k].pop_front());
    end
  endtask

  function automatic logic [2*NB-1:0] exp_owner();
    logic [2*NB-1:0] o;
    o = '0;
    for (int k = 0; k < 3; k++)
      if (ag[k] >= 0) o[2*ag[k] +: 2] = 2'(k + 1);
    return o;
  endfunction

  task automatic compare_all();
    n_vec++;
    chk("sn_valid",  32'(bus.sn_valid),  32'(ag[0] >= 0));
    if (ag[0] >= 0) chk("sn_sel",  32'(bus.sn_sel),  ag[0]);
    chk("cpu_valid", 32'(bus.cpu_valid), 32'(ag[1] >= 0));
    if (ag[1] >= 0) chk("cpu_sel", 32'(bus.cpu_sel), ag[1]);
    chk("fwd_valid", 32'(bus.fwd_valid), 32'(ag[2] >= 0));
    if (ag[2] >= 0) chk("fwd_sel", 32'(bus.fwd_sel), ag[2]);
    chk("buf_owner", 32'(bus.buf_owner), 32'(exp_owner()));
    chk("len_rst",   32'(bus.len_rst),   32'(m_len));
    chk("free_count", 32'(bus.free_count), q[0].size());
    chk("proto_err", 32'(bus.proto_err), 32'(m_err));
  endtask

  task automatic cyc(input bit s, input bit a, input bit r, input bit f);
    bus.sn_done = s; bus.cpu_acc = a; bus.cpu_rej = r; bus.fwd_done = f;
    @(posedge clk);
    model_step(s, a, r, f);
    #1;
    compare_all();
    bus.sn_done = 0; bus.cpu_acc = 0; bus.cpu_rej = 0; bus.fwd_done = 0;
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge arrives.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_sn_valid",  32'(bus.sn_valid),  1);
    chk("rst_sn_sel",    32'(bus.sn_sel),    0);
    chk("rst_cpu_valid", 32'(bus.cpu_valid), 0);
    chk("rst_fwd_valid", 32'(bus.fwd_valid), 0);
    chk("rst_cpu_sel",   32'(bus.cpu_sel),   0);
    chk("rst_fwd_sel",   32'(bus.fwd_sel),   0);
    chk("rst_free_count", 32'(bus.free_count), 3);
    chk("rst_buf_owner", 32'(bus.buf_owner), 32'h01);
    chk("rst_len_rst",   32'(bus.len_rst),   0);
    chk("rst_proto_err", 32'(bus.proto_err), 0);
    #2 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.sn_done = 0; bus.cpu_acc = 0; bus.cpu_rej = 0; bus.fwd_done = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset_pulse();

    // Snooper hands buffer 0 to the CPU, then accept and forward it.
    cyc(1, 0, 0, 0);
    chk("s1_cpu_sel", 32'(bus.cpu_sel), 0);
    chk("s1_cpu_valid", 32'(bus.cpu_valid), 1);
    chk("s1_sn_sel", 32'(bus.sn_sel), 1);
    chk("s1_free_count", 32'(bus.free_count), 2);
    chk("s1_buf_owner", 32'(bus.buf_owner), 32'b00_00_01_10);
    cyc(0, 1, 0, 0);
    chk("s1_fwd_sel", 32'(bus.fwd_sel), 0);
    chk("s1_fwd_valid", 32'(bus.fwd_valid), 1);
    cyc(0, 0, 0, 1);
    chk("s1_len_rst", 32'(bus.len_rst), 32'b0001);
    chk("s1_free_count_inc", 32'(bus.free_count), 3);
    cyc(0, 0, 0, 0);
    chk("s1_len_rst_clear", 32'(bus.len_rst), 0);

    // CPU stalled while the snooper exhausts the pool.
    reset_pulse();
    repeat (4) cyc(1, 0, 0, 0);
    chk("s2_sn_valid", 32'(bus.sn_valid), 0);
    chk("s2_cpu_sel", 32'(bus.cpu_sel), 0);
    chk("s2_free_count", 32'(bus.free_count), 0);
    cyc(1, 0, 0, 0);
    chk("s2_sn_err", 32'(bus.proto_err), 1);
    cyc(0, 0, 1, 0);
    chk("s2_sn_sel", 32'(bus.sn_sel), 0);
    chk("s2_sn_valid_back", 32'(bus.sn_valid), 1);
    chk("s2_cpu_sel_next", 32'(bus.cpu_sel), 1);
    chk("s2_len_rst", 32'(bus.len_rst), 32'b0001);

    // Simultaneous reject and forward-done with an idle snooper, then acc+rej.
    reset_pulse();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    chk("s3_sn_valid", 32'(bus.sn_valid), 0);
    cyc(0, 0, 1, 1);
    chk("s3_sn_sel", 32'(bus.sn_sel), 1);
    chk("s3_free_count", 32'(bus.free_count), 1);
    chk("s3_cpu_sel", 32'(bus.cpu_sel), 2);
    chk("s3_len_rst", 32'(bus.len_rst), 32'b0011);
    chk("s3_fwd_valid", 32'(bus.fwd_valid), 0);
    cyc(0, 1, 1, 0);
    chk("s3_fwd_sel", 32'(bus.fwd_sel), 2);
    chk("s3_cpu_sel_acc", 32'(bus.cpu_sel), 3);
    chk("s3_proto_err", 32'(bus.proto_err), 1);

    // Random traffic with occasional mid-traffic resets.
    reset_pulse();
    for (int n = 0; n < 3000; n++) begin
      bit s, a, r, f;
      s = ($urandom_range(0, 99) < 45);
      a = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 20);
      f = ($urandom_range(0, 99) < 35);
      cyc(s, a, r, f);
      if (n % 700 == 350) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/buf_pool_ctrl.md
Name: buf_pool_ctrl

Overview:
Ownership scheduler for a pool of NUM_BUFS packet_ram buffers shared by snooper (producer), CPU (filter) and forwarder (consumer). It is the N-buffer generalisation of the three-buffer rotation. Index FIFOs hold free, CPU-pending and forward-pending buffers; per-buffer owner codes drive the buffer muxes and length resets. Accepted packets keep their order.

Parameters:
NUM_BUFS, 4, number of buffers in the pool; range 2 to 2**IDX_WIDTH.
IDX_WIDTH, 2, width of a buffer index.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
sn_done  in  1  1-cycle pulse: snooper finished its buffer
cpu_acc  in  1  1-cycle pulse: CPU accepts its buffer
cpu_rej  in  1  1-cycle pulse: CPU rejects its buffer
fwd_done  in  1  1-cycle pulse: forwarder finished its buffer
sn_sel  out  IDX_WIDTH  index of the buffer owned by the snooper
sn_valid  out  1  snooper owns a buffer
cpu_sel  out  IDX_WIDTH  index of the buffer owned by the CPU
cpu_valid  out  1  CPU owns a buffer
fwd_sel  out  IDX_WIDTH  index of the buffer owned by the forwarder
fwd_valid  out  1  forwarder owns a buffer
buf_owner  out  2*NUM_BUFS  per-buffer owner code; buffer i uses bits [2i+1:2i]
len_rst  out  NUM_BUFS  1-cycle pulse; bit i clears buffer i's length
free_count  out  IDX_WIDTH+1  number of entries in the free queue
proto_err  out  1  1-cycle pulse when an event is ignored

Behaviour:
- Owner codes: 00 queued/free, 01 snooper, 10 CPU, 11 forwarder.
- Conservation invariant: each buffer is in exactly one place, either one agent or one queue.
- Reset (async, all state):
  - sn_valid=1, sn_sel=0.
  - cpu_valid=0, fwd_valid=0, cpu_sel=0, fwd_sel=0.
  - Free queue holds 1..NUM_BUFS-1 in order; other queues empty.
  - free_count=NUM_BUFS-1, buf_owner has only buffer 0 = 01.
  - len_rst=0, proto_err=0.
- All outputs are registered. An event at edge t takes effect at t+1.
- Routing: each agent releases its buffer into a destination queue.
  - sn_done sends the buffer to the CPU-pending queue.
  - cpu_acc sends it to the forward-pending queue.
  - cpu_rej and fwd_done send it to the free queue.
- Refill: an agent that is idle, or releasing this cycle, takes the head of its source queue at t+1.
  - Sources: snooper from free, CPU from CPU-pending, forwarder from forward-pending.
  - Bypass: if the source queue is empty and a buffer enters it this cycle, the buffer goes straight to the agent at t+1 and is not queued.
  - If nothing is available, valid=0 until a buffer arrives.
- len_rst[i] pulses at t+1 when buffer i is released by cpu_rej or fwd_done.
- Free-queue ordering: it accepts two pushes per cycle.
  - The cpu_rej buffer is ordered ahead of the fwd_done buffer.
  - With the bypass, the snooper takes the cpu_rej buffer; the fwd_done buffer is queued.
- CPU-pending and forward-pending queues: one push and one pop per cycle.
- Queue depth is NUM_BUFS, so queues never overflow by construction.
- Ignored events, each giving a proto_err pulse at t+1 and no state change:
  - a done/acc/rej pulse while the matching agent's valid=0;
  - cpu_acc and cpu_rej in the same cycle: acc is honoured, rej is dropped and flagged.
- Simultaneous events from different agents in one cycle are all honoured.
- Snooper starvation: when the snooper holds no buffer, incoming packets are the snooper's to drop. This block does not drop anything.
- Reset mid-operation discards all ownership immediately, without waiting for a clock edge.

Decomposition:
- Shared package/header:
  - owner-code constants OWN_FREE=2'b00, OWN_SN=2'b01, OWN_CPU=2'b10, OWN_FWD=2'b11;
  - index-width helper.
- Sub-module idx_fifo: index FIFO with parameters DEPTH, WIDTH and an optional second write port. It is instantiated three times; only the free queue enables the second port.

Test Plan:
- Reset with NUM_BUFS=4 -> sn_sel=0, sn_valid=1, cpu_valid=0, fwd_valid=0, free_count=3, buf_owner=8'b00_00_00_01.
- sn_done at t -> at t+1: cpu_sel=0, cpu_valid=1, sn_sel=1, free_count=2, buf_owner=8'b00_00_01_10.
- From that state, cpu_acc -> fwd_sel=0; then fwd_done -> len_rst=4'b0001 for one cycle and free_count increments.
- CPU stalled, four sn_done pulses -> CPU holds 0, CPU-pending queue [1,2,3], sn_valid=0, free_count=0. Then cpu_rej -> at t+1: sn_sel=0, cpu_sel=1, len_rst[0] pulses.
- With snooper idle, cpu_rej and fwd_done in the same cycle -> snooper gets the CPU's buffer and free_count=1. Separately, cpu_acc with cpu_rej -> accept taken and proto_err pulses.
- Async rst asserted mid-traffic, between edges -> all outputs return to reset values immediately.
